// File: rtl/seg7_pkg.sv
// Shared types and constants for the 8-digit 7-segment scan serializer.
package seg7_pkg;

    localparam int N_DIGITS = 8;
    localparam int WORD_W   = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH,
        HOLD
    } state_t;

    // Hex nibble to segment pattern, bit order {g,f,e,d,c,b,a}, 1 = lit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_encoder.sv
// Turns one digit (nibble, decimal point, blank flag) into an active-high segment byte.
module seg7_hex_encoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    // Blanking wins over both the glyph and the decimal point.
    always_comb begin
        seg = 8'h00;
        if (!blank) begin
            seg = {dp, hex_to_seg(nibble)};
        end
    end

endmodule

// File: rtl/seg7_scan_serializer.sv
// Scans 8 hex digits and shifts one {seg, digit_sel} word per digit into a 74HC595 chain.
module seg7_scan_serializer
    import seg7_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int HOLD_CYCLES = 0,
    parameter bit SEG_INV     = 1'b0,
    parameter bit DIG_INV     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [4*N_DIGITS-1:0] digits_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    input  logic [N_DIGITS-1:0]   blank_i,
    output logic                  sclk,
    output logic                  serial_data,
    output logic                  rclk,
    output logic [4:0]            line_counter,
    output logic [4:0]            s_counter,
    output logic [WORD_W-1:0]     line_data
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] DIV_LAST     = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] RCLK_RISE_AT = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] RCLK_FALL_AT = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST   = CNT_W'(4 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [4:0]       LAST_DIGIT   = 5'(N_DIGITS - 1);
    localparam logic [4:0]       LAST_BIT     = 5'(WORD_W - 1);

    state_t                state;
    logic [CNT_W-1:0]      phase_cnt;
    logic [4*N_DIGITS-1:0] frame_digits;
    logic [N_DIGITS-1:0]   frame_dp;
    logic [N_DIGITS-1:0]   frame_blank;

    logic [4*N_DIGITS-1:0] src_digits;
    logic [N_DIGITS-1:0]   src_dp;
    logic [N_DIGITS-1:0]   src_blank;
    logic [2:0]            digit_idx;
    logic [3:0]            cur_nibble;
    logic [7:0]            enc_seg;
    logic [WORD_W-1:0]     next_word;
    logic [3:0]            next_bit_idx;
    logic [4:0]            next_line;

    assign digit_idx    = line_counter[2:0];
    assign cur_nibble   = src_digits[{digit_idx, 2'b00} +: 4];
    assign next_bit_idx = 4'd14 - s_counter[3:0];
    assign next_line    = (line_counter == LAST_DIGIT) ? 5'd0 : line_counter + 5'd1;
    assign next_word    = {enc_seg ^ {8{SEG_INV}}, (8'h01 << digit_idx) ^ {8{DIG_INV}}};

    // Digit 0 reads the live inputs (they are snapshotted that same cycle); later digits read the frame copy.
    always_comb begin
        src_digits = frame_digits;
        src_dp     = frame_dp;
        src_blank  = frame_blank;
        if (line_counter == 5'd0) begin
            src_digits = digits_i;
            src_dp     = dp_i;
            src_blank  = blank_i;
        end
    end

    seg7_hex_encoder u_encoder (
        .nibble (cur_nibble),
        .dp     (src_dp[digit_idx]),
        .blank  (src_blank[digit_idx]),
        .seg    (enc_seg)
    );

    // Scan FSM: load a word, shift 16 bits MSB-first, pulse the latch, hold, then move to the next digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            phase_cnt    <= '0;
            sclk         <= 1'b0;
            rclk         <= 1'b0;
            serial_data  <= 1'b0;
            line_counter <= '0;
            s_counter    <= '0;
            line_data    <= '0;
            frame_digits <= '0;
            frame_dp     <= '0;
            frame_blank  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (line_counter == 5'd0) begin
                        frame_digits <= digits_i;
                        frame_dp     <= dp_i;
                        frame_blank  <= blank_i;
                    end
                    line_data   <= next_word;
                    serial_data <= next_word[WORD_W-1];
                    s_counter   <= '0;
                    sclk        <= 1'b0;
                    phase_cnt   <= '0;
                    state       <= SHIFT;
                end
                SHIFT: begin
                    if (phase_cnt != DIV_LAST) begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end else begin
                        phase_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk      <= 1'b0;
                            s_counter <= s_counter + 5'd1;
                            if (s_counter == LAST_BIT) begin
                                state <= LATCH;
                            end else begin
                                serial_data <= line_data[next_bit_idx];
                            end
                        end
                    end
                end
                LATCH: begin
                    if (phase_cnt == RCLK_RISE_AT) begin
                        rclk <= 1'b1;
                    end
                    if (phase_cnt == RCLK_FALL_AT) begin
                        rclk <= 1'b0;
                    end
                    if (phase_cnt != LATCH_LAST) begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end else begin
                        phase_cnt <= '0;
                        if (HOLD_CYCLES == 0) begin
                            line_counter <= next_line;
                            state        <= enable ? LOAD : IDLE;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (phase_cnt != HOLD_LAST) begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end else begin
                        phase_cnt    <= '0;
                        line_counter <= next_line;
                        state        <= enable ? LOAD : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_serializer.sv
// Self-checking bench: a 595 model per DUT feeds latched words to a scoreboard of expected words.
module tb_seg7_scan_serializer;

    typedef struct packed {
        logic [15:0] word;
        logic [4:0]  idx;
    } exp_t;

    typedef struct packed {
        logic [31:0]       digits;
        logic [7:0]        dp;
        logic [7:0]        blank;
        logic [7:0][15:0]  words;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable0 = 1'b0, enable1 = 1'b0;
    logic [31:0] digits0 = '0, digits1 = '0;
    logic [7:0]  dp0 = '0, dp1 = '0, blank0 = '0, blank1 = '0;
    logic        sclk0, sdata0, rclk0, sclk1, sdata1, rclk1;
    logic [4:0]  lc0, sc0, lc1, sc1;
    logic [15:0] ld0, ld1;

    int          chk_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    int          overlap_cnt = 0;
    int          unstable_cnt = 0;
    bit          check_period = 1'b0;
    int          sclk_rises [2] = '{0, 0};
    int          lat_cnt [2] = '{0, 0};
    int          prev_rclk_cyc [2] = '{-1, -1};
    logic [15:0] shreg [2] = '{16'h0, 16'h0};
    logic        sclk_q [2] = '{1'b0, 1'b0};
    logic        rclk_q [2] = '{1'b0, 1'b0};
    logic        sd_q [2] = '{1'b0, 1'b0};
    exp_t        exp_q0 [$];
    exp_t        exp_q1 [$];
    vec_t        vecs [3];

    always #5 clk = ~clk;

    seg7_scan_serializer dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable0),
        .digits_i     (digits0),
        .dp_i         (dp0),
        .blank_i      (blank0),
        .sclk         (sclk0),
        .serial_data  (sdata0),
        .rclk         (rclk0),
        .line_counter (lc0),
        .s_counter    (sc0),
        .line_data    (ld0)
    );

    seg7_scan_serializer #(
        .CLK_DIV     (1),
        .HOLD_CYCLES (3),
        .SEG_INV     (1'b1),
        .DIG_INV     (1'b1)
    ) dut_inv (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable1),
        .digits_i     (digits1),
        .dp_i         (dp1),
        .blank_i      (blank1),
        .sclk         (sclk1),
        .serial_data  (sdata1),
        .rclk         (rclk1),
        .line_counter (lc1),
        .s_counter    (sc1),
        .line_data    (ld1)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        chk_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
            4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
            4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
            4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
        endcase
        return g;
    endfunction

    function automatic logic [15:0] expWord(input logic [31:0] dg, input logic [7:0] dp,
                                            input logic [7:0] bl, input int k, input bit inv);
        logic [7:0] seg;
        logic [7:0] dsel;
        seg = bl[k] ? 8'h00 : {dp[k], glyph(dg[4*k +: 4])};
        dsel = 8'h00;
        dsel[k] = 1'b1;
        if (inv) begin
            seg  = ~seg;
            dsel = ~dsel;
        end
        return {seg, dsel};
    endfunction

    task automatic pushExp(input int d, input logic [15:0] word, input int idx);
        exp_t e;
        e.word = word;
        e.idx  = 5'(idx);
        if (d == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
    endtask

    task automatic pushFrame(input int d, input logic [31:0] dg, input logic [7:0] dp,
                             input logic [7:0] bl, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            pushExp(d, expWord(dg, dp, bl, k, d == 1), k);
        end
    endtask

    task automatic applyStimulus(input int d, input logic [31:0] dg, input logic [7:0] dp, input logic [7:0] bl);
        if (d == 0) begin
            digits0 = dg; dp0 = dp; blank0 = bl;
        end else begin
            digits1 = dg; dp1 = dp; blank1 = bl;
        end
    endtask

    task automatic setEnable(input int d, input logic v);
        if (d == 0) enable0 = v;
        else enable1 = v;
    endtask

    task automatic waitLatches(input int d, input int target);
        int budget;
        budget = 3000;
        while (lat_cnt[d] < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) checkOutput("latch_timeout", lat_cnt[d], target);
    endtask

    // Run n words from idle, dropping enable while the last word is shifting.
    task automatic runWords(input int d, input int n);
        int start;
        start = lat_cnt[d];
        setEnable(d, 1'b1);
        waitLatches(d, start + n - 1);
        repeat (10) @(negedge clk);
        setEnable(d, 1'b0);
        waitLatches(d, start + n);
        repeat (150) @(negedge clk);
        checkOutput("no_extra_latch", lat_cnt[d], start + n);
        checkOutput("queue_drained", (d == 0) ? exp_q0.size() : exp_q1.size(), 0);
    endtask

    // 595 model: shift on sclk rise, latch on rclk rise, then score the latched word.
    task automatic monitorStep(input int d, input logic sc, input logic rc, input logic sd,
                               input logic [15:0] ld, input logic [4:0] lc, input logic rs);
        exp_t e;
        if (rs) begin
            sclk_rises[d]    = 0;
            prev_rclk_cyc[d] = -1;
        end else begin
            if (sc && !sclk_q[d]) begin
                shreg[d] = {shreg[d][14:0], sd};
                sclk_rises[d]++;
            end
            if (sc && sclk_q[d] && (sd !== sd_q[d])) unstable_cnt++;
            if (sc && rc) overlap_cnt++;
            if (rc && !rclk_q[d]) begin
                lat_cnt[d]++;
                checkOutput("bits_per_word", sclk_rises[d], 16);
                sclk_rises[d] = 0;
                if (check_period && prev_rclk_cyc[d] >= 0) begin
                    checkOutput("rclk_period", cyc - prev_rclk_cyc[d], (d == 0) ? 73 : 40);
                end
                prev_rclk_cyc[d] = cyc;
                if (((d == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
                    checkOutput("unexpected_latch", shreg[d], 32'hFFFF_FFFF);
                end else begin
                    if (d == 0) e = exp_q0.pop_front();
                    else e = exp_q1.pop_front();
                    checkOutput("latched_word", shreg[d], e.word);
                    checkOutput("line_data_at_latch", ld, e.word);
                    checkOutput("line_counter_at_latch", lc, e.idx);
                end
            end
        end
        sclk_q[d] = sc;
        rclk_q[d] = rc;
        sd_q[d]   = sd;
    endtask

    // Sample both DUTs on the falling clock edge, away from the registers' update edge.
    always @(negedge clk) begin
        cyc++;
        monitorStep(0, sclk0, rclk0, sdata0, ld0, lc0, rst);
        monitorStep(1, sclk1, rclk1, sdata1, ld1, lc1, rst);
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", err_cnt);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start;
        int budget;

        vecs[0] = '{digits: 32'h76543210, dp: 8'h00, blank: 8'h00,
                    words: {16'h0780, 16'h7D40, 16'h6D20, 16'h6610, 16'h4F08, 16'h5B04, 16'h0602, 16'h3F01}};
        vecs[1] = '{digits: 32'hFEDCBA98, dp: 8'hA5, blank: 8'h00,
                    words: {16'hF180, 16'h7940, 16'hDE20, 16'h3910, 16'h7C08, 16'hF704, 16'h6F02, 16'hFF01}};
        vecs[2] = '{digits: 32'h1234ABCD, dp: 8'hFF, blank: 8'h0F,
                    words: {16'h8680, 16'hDB40, 16'hCF20, 16'hE610, 16'h0008, 16'h0004, 16'h0002, 16'h0001}};

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("reset_sclk", sclk0, 0);
        checkOutput("reset_rclk", rclk0, 0);
        checkOutput("reset_serial_data", sdata0, 0);
        checkOutput("reset_line_counter", lc0, 0);
        checkOutput("reset_s_counter", sc0, 0);
        checkOutput("reset_line_data", ld0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven frames on the default DUT
        for (int i = 0; i < 3; i++) begin
            $display("[TB] frame vector %0d digits=%h", i, vecs[i].digits);
            applyStimulus(0, vecs[i].digits, vecs[i].dp, vecs[i].blank);
            for (int k = 0; k < 8; k++) pushExp(0, vecs[i].words[k], k);
            runWords(0, 8);
            checkOutput("idle_line_counter_wrapped", lc0, 0);
        end

        // Inverted DUT: CLK_DIV=1, HOLD_CYCLES=3, both bytes inverted
        check_period = 1'b1;
        prev_rclk_cyc[1] = -1;
        applyStimulus(1, 32'h76543210, 8'h01, 8'h00);
        pushExp(1, 16'h40FE, 0);
        pushFrame(1, 32'h76543210, 8'h01, 8'h00, 1, 7);
        runWords(1, 8);
        check_period = 1'b0;
        applyStimulus(1, 32'h76543210, 8'h01, 8'h01);
        pushExp(1, 16'hFFFE, 0);
        runWords(1, 1);

        // Frame snapshot: inputs changed at digit 3 appear only in the next frame
        $display("[TB] tearing sequence");
        check_period = 1'b1;
        prev_rclk_cyc[0] = -1;
        applyStimulus(0, 32'h76543210, 8'h00, 8'h00);
        pushFrame(0, 32'h76543210, 8'h00, 8'h00, 0, 7);
        start = lat_cnt[0];
        enable0 = 1'b1;
        budget = 1000;
        while (lc0 != 5'd3 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) checkOutput("wait_line_counter3", lc0, 3);
        applyStimulus(0, 32'hFEDCBA98, 8'h00, 8'h00);
        pushFrame(0, 32'hFEDCBA98, 8'h00, 8'h00, 0, 7);
        waitLatches(0, start + 15);
        repeat (10) @(negedge clk);
        enable0 = 1'b0;
        waitLatches(0, start + 16);
        repeat (150) @(negedge clk);
        check_period = 1'b0;
        checkOutput("tear_latch_count", lat_cnt[0], start + 16);
        checkOutput("tear_queue_drained", exp_q0.size(), 0);

        // Enable dropped mid-word: word completes, one latch, then idle one digit further on
        $display("[TB] enable drop sequence");
        pushExp(0, expWord(32'hFEDCBA98, 8'h00, 8'h00, 0, 1'b0), 0);
        start = lat_cnt[0];
        enable0 = 1'b1;
        budget = 300;
        while (sc0 != 5'd5 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) checkOutput("wait_s_counter5", sc0, 5);
        enable0 = 1'b0;
        waitLatches(0, start + 1);
        repeat (150) @(negedge clk);
        checkOutput("drop_single_latch", lat_cnt[0], start + 1);
        checkOutput("drop_line_counter", lc0, 1);
        checkOutput("drop_idle_sclk", sclk0, 0);
        checkOutput("drop_idle_rclk", rclk0, 0);
        pushExp(0, expWord(32'hFEDCBA98, 8'h00, 8'h00, 1, 1'b0), 1);
        runWords(0, 1);

        // Reset mid-shift: outputs clear next cycle, no latch, restart at digit 0
        $display("[TB] reset mid-shift sequence");
        start = lat_cnt[0];
        enable0 = 1'b1;
        budget = 300;
        while (sc0 != 5'd9 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) checkOutput("wait_s_counter9", sc0, 9);
        rst = 1'b1;
        enable0 = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_sclk", sclk0, 0);
        checkOutput("post_reset_rclk", rclk0, 0);
        checkOutput("post_reset_serial_data", sdata0, 0);
        checkOutput("post_reset_line_counter", lc0, 0);
        checkOutput("post_reset_s_counter", sc0, 0);
        checkOutput("post_reset_line_data", ld0, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        checkOutput("no_rclk_on_reset", lat_cnt[0], start);
        pushExp(0, expWord(32'hFEDCBA98, 8'h00, 8'h00, 0, 1'b0), 0);
        runWords(0, 1);

        checkOutput("sclk_rclk_overlap", overlap_cnt, 0);
        checkOutput("sdata_unstable_while_sclk_high", unstable_cnt, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
